// File: rtl/uart_transmitter_fsm_pkg.sv
// Shared UART definitions: frame geometry, state encodings and parity sense.
// The receiver FSM imports the same package so both ends agree on framing.
package uart_transmitter_fsm_pkg;

    // Clock cycles per serial bit on the 16x baud clock.
    localparam int unsigned OVERSAMPLE = 16;
    // Payload width; a frame is start + data + parity + stop.
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = DATA_BITS + 3;

    // Counter widths derived from the frame geometry.
    localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W   = $clog2(DATA_BITS);
    localparam int unsigned STATE_W = 3;

    // State encodings, shared with the receiver.
    localparam logic [STATE_W-1:0] IDLE   = STATE_W'(0);
    localparam logic [STATE_W-1:0] START  = STATE_W'(1);
    localparam logic [STATE_W-1:0] DATA   = STATE_W'(2);
    localparam logic [STATE_W-1:0] PARITY = STATE_W'(3);
    localparam logic [STATE_W-1:0] STOP   = STATE_W'(4);

    // Last tick of a bit period and last data bit index.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // Parity sense: 1 selects odd parity (ones over data+parity is odd).
    localparam logic PARITY_ODD = 1'b1;

    typedef logic [DATA_BITS-1:0] uartData_t;

    // Latched transmit payload: shifting data plus the parity computed at accept.
    typedef struct packed {
        uartData_t data;
        logic      parity;
    } txPayload_t;

endpackage

// File: rtl/uart_transmitter_fsm_if.sv
// Byte handshake and line signals between a byte source and the UART transmitter.
interface uart_transmitter_fsm_if;
    import uart_transmitter_fsm_pkg::*;

    uartData_t dataIn;
    logic      sendData;
    logic      ready;
    logic      serialOutput;
    logic      done;

    // Byte source side.
    modport master (
        output dataIn,
        output sendData,
        input  ready,
        input  serialOutput,
        input  done
    );

    // Transmitter side.
    modport slave (
        input  dataIn,
        input  sendData,
        output ready,
        output serialOutput,
        output done
    );

endinterface

// File: rtl/uart_transmitter_fsm_odd_parity.sv
// Combinational parity generator for one UART payload; also used by the receiver check.
module odd_parity
    import uart_transmitter_fsm_pkg::*;
(
    input  uartData_t data,
    output logic      parity_c
);

    // XOR-reduce the payload, then invert for odd sense.
    always_comb begin
        parity_c = (^data) ^ PARITY_ODD;
    end

endmodule

// File: rtl/uart_transmitter_fsm.sv
// UART transmitter: accepts one byte per handshake and sends start, 8 data bits
// LSB first, odd parity and stop, each held for OVERSAMPLE baud-clock cycles.
module uart_transmitter_fsm
    import uart_transmitter_fsm_pkg::*;
(
    input  logic                   baudRateOut,
    input  logic                   rst,
    uart_transmitter_fsm_if.slave  bus
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] stateNext;
    logic [TICK_W-1:0]  tick;
    logic [TICK_W-1:0]  tickNext;
    logic [BIT_W-1:0]   bitCnt;
    logic [BIT_W-1:0]   bitCntNext;
    txPayload_t         payload;
    txPayload_t         payloadNext;
    logic               serialReg;
    logic               serialNext;
    logic               readyReg;
    logic               readyNext;
    logic               doneReg;
    logic               doneNext;
    logic               parityIn_c;
    logic               tickLast_c;

    // Parity of the incoming byte, latched together with it on accept.
    odd_parity u_parity (
        .data     (bus.dataIn),
        .parity_c (parityIn_c)
    );

    assign tickLast_c = (tick == TICK_LAST);

    // Next-state and next-output logic; every target gets a hold/idle default first.
    always_comb begin
        stateNext   = state;
        tickNext    = tick;
        bitCntNext  = bitCnt;
        payloadNext = payload;
        serialNext  = serialReg;
        readyNext   = readyReg;
        doneNext    = 1'b0;

        case (state)
            IDLE: begin
                serialNext = 1'b1;
                readyNext  = 1'b1;
                tickNext   = '0;
                bitCntNext = '0;
                if (readyReg && bus.sendData) begin
                    payloadNext = '{data: bus.dataIn, parity: parityIn_c};
                    stateNext   = START;
                    readyNext   = 1'b0;
                    serialNext  = 1'b0;
                end
            end

            START: begin
                serialNext = 1'b0;
                tickNext   = tickLast_c ? '0 : tick + TICK_W'(1);
                if (tickLast_c) begin
                    stateNext  = DATA;
                    serialNext = payload.data[0];
                end
            end

            DATA: begin
                serialNext = payload.data[0];
                tickNext   = tickLast_c ? '0 : tick + TICK_W'(1);
                if (tickLast_c) begin
                    if (bitCnt == BIT_LAST) begin
                        stateNext  = PARITY;
                        bitCntNext = '0;
                        serialNext = payload.parity;
                    end else begin
                        bitCntNext       = bitCnt + BIT_W'(1);
                        payloadNext.data = payload.data >> 1;
                        serialNext       = payload.data[1];
                    end
                end
            end

            PARITY: begin
                serialNext = payload.parity;
                tickNext   = tickLast_c ? '0 : tick + TICK_W'(1);
                if (tickLast_c) begin
                    stateNext  = STOP;
                    serialNext = 1'b1;
                end
            end

            STOP: begin
                serialNext = 1'b1;
                tickNext   = tickLast_c ? '0 : tick + TICK_W'(1);
                if (tickLast_c) begin
                    stateNext = IDLE;
                    readyNext = 1'b1;
                    doneNext  = 1'b1;
                end
            end

            // Unreachable encodings fall back to the idle/reset picture.
            default: begin
                stateNext   = IDLE;
                tickNext    = '0;
                bitCntNext  = '0;
                payloadNext = '0;
                serialNext  = 1'b1;
                readyNext   = 1'b1;
                doneNext    = 1'b0;
            end
        endcase
    end

    // State, counters, payload and registered outputs; synchronous reset wins over any request.
    always_ff @(posedge baudRateOut) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= '0;
            bitCnt    <= '0;
            payload   <= '0;
            serialReg <= 1'b1;
            readyReg  <= 1'b1;
            doneReg   <= 1'b0;
        end else begin
            state     <= stateNext;
            tick      <= tickNext;
            bitCnt    <= bitCntNext;
            payload   <= payloadNext;
            serialReg <= serialNext;
            readyReg  <= readyNext;
            doneReg   <= doneNext;
        end
    end

    assign bus.serialOutput = serialReg;
    assign bus.ready        = readyReg;
    assign bus.done         = doneReg;

endmodule

// File: tb/tb_uart_transmitter_fsm.sv
// Directed and random frames checked cycle by cycle against a frame-level line model,
// plus a behavioural mid-bit sampling receiver on the same baud clock.
module tb_uart_transmitter_fsm;
    import uart_transmitter_fsm_pkg::*;

    localparam int BIT_CYC   = 16;
    localparam int FRAME_CYC = FRAME_BITS * BIT_CYC;

    logic baudRateOut;
    logic rst;
    int   checks;
    int   failures;
    int   curT;

    uart_transmitter_fsm_if bus();

    uart_transmitter_fsm dut (
        .baudRateOut (baudRateOut),
        .rst         (rst),
        .bus         (bus)
    );

    initial baudRateOut = 1'b0;
    always #5 baudRateOut = ~baudRateOut;

    // Reference: parity makes total ones odd.
    function automatic logic refParity(input logic [7:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Reference: line level during cycle t (1..FRAME_CYC) after the accept edge.
    function automatic logic refLine(input logic [7:0] d, input int t);
        int k;
        k = (t - 1) / BIT_CYC;
        if (k == 0)       return 1'b0;
        else if (k <= 8)  return d[k-1];
        else if (k == 9)  return refParity(d);
        else              return 1'b1;
    endfunction

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, curT, obs, exp);
        end
    endtask

    task automatic chkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, curT, obs, exp);
        end
    endtask

    task automatic idleCheck(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge baudRateOut);
            curT = -1;
            chkBit("idleLine", bus.serialOutput, 1'b1);
            chkBit("idleReady", bus.ready, 1'b1);
            chkBit("idleDone", bus.done, 1'b0);
        end
    endtask

    // Send one frame starting from a negedge with ready high; returns at the negedge
    // of cycle FRAME_CYC+1 where done/ready must be high.
    task automatic runFrame(input logic [7:0] d, input bit holdSend, input int glitchAt,
                            input bit scramble);
        logic [10:0] rxBits;
        rxBits = '0;
        curT = 0;
        chkBit("readyPre", bus.ready, 1'b1);
        bus.dataIn   = d;
        bus.sendData = 1'b1;
        @(posedge baudRateOut);
        for (int t = 1; t <= FRAME_CYC; t++) begin
            @(negedge baudRateOut);
            curT = t;
            if (!holdSend) bus.sendData = (t == glitchAt);
            if (scramble) bus.dataIn = 8'($urandom);
            chkBit("line", bus.serialOutput, refLine(d, t));
            chkBit("readyBusy", bus.ready, 1'b0);
            chkBit("doneBusy", bus.done, 1'b0);
            if ((t - 1) % BIT_CYC == BIT_CYC / 2) rxBits[(t - 1) / BIT_CYC] = bus.serialOutput;
        end
        @(negedge baudRateOut);
        curT = FRAME_CYC + 1;
        chkBit("endLine", bus.serialOutput, 1'b1);
        chkBit("endReady", bus.ready, 1'b1);
        chkBit("endDone", bus.done, 1'b1);
        chkBit("rxStart", rxBits[0], 1'b0);
        chkByte("rxData", rxBits[8:1], d);
        chkBit("rxParity", rxBits[9], refParity(d));
        chkBit("rxStop", rxBits[10], 1'b1);
    endtask

    // Start a frame, then assert reset during cycle `at` and verify the abandon.
    task automatic resetMid(input logic [7:0] d, input int at);
        bus.dataIn   = d;
        bus.sendData = 1'b1;
        @(posedge baudRateOut);
        for (int t = 1; t <= at; t++) begin
            @(negedge baudRateOut);
            curT = t;
            bus.sendData = 1'b0;
            chkBit("preRstLine", bus.serialOutput, refLine(d, t));
        end
        rst = 1'b1;
        @(negedge baudRateOut);
        curT = at + 1;
        rst = 1'b0;
        chkBit("rstLine", bus.serialOutput, 1'b1);
        chkBit("rstReady", bus.ready, 1'b1);
        chkBit("rstDone", bus.done, 1'b0);
        idleCheck(FRAME_CYC);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        curT         = 0;
        rst          = 1'b1;
        bus.sendData = 1'b0;
        bus.dataIn   = 8'h00;

        // Reset held for two edges.
        repeat (2) @(negedge baudRateOut);
        chkBit("rstValLine", bus.serialOutput, 1'b1);
        chkBit("rstValReady", bus.ready, 1'b1);
        chkBit("rstValDone", bus.done, 1'b0);
        rst = 1'b0;
        idleCheck(2);

        // Directed bytes with known parity.
        runFrame(8'h55, 1'b0, 0, 1'b0);
        idleCheck(3);
        runFrame(8'h00, 1'b0, 0, 1'b0);
        idleCheck(2);
        runFrame(8'hFF, 1'b0, 0, 1'b1);
        idleCheck(2);
        runFrame(8'h01, 1'b0, 0, 1'b1);

        // Back-to-back with sendData held high and dataIn scrambled mid-frame.
        runFrame(8'hA3, 1'b1, 0, 1'b1);
        runFrame(8'h3C, 1'b0, 0, 1'b1);
        idleCheck(2);

        // Request pulse during cycle 40 must be ignored; exactly one frame.
        runFrame(8'($urandom), 1'b0, 40, 1'b1);
        idleCheck(FRAME_CYC);

        // Reset mid-DATA, then a clean frame.
        resetMid(8'($urandom), 90);
        runFrame(8'($urandom), 1'b0, 0, 1'b0);
        idleCheck(1);

        // Reset and request together: reset wins.
        rst          = 1'b1;
        bus.sendData = 1'b1;
        bus.dataIn   = 8'h5A;
        @(negedge baudRateOut);
        curT = -2;
        chkBit("rstSendLine", bus.serialOutput, 1'b1);
        chkBit("rstSendReady", bus.ready, 1'b1);
        rst          = 1'b0;
        bus.sendData = 1'b0;
        idleCheck(4);

        // Loopback byte through the behavioural receiver.
        runFrame(8'hA3, 1'b0, 0, 1'b0);
        idleCheck(1);

        // Random traffic.
        for (int i = 0; i < 4; i++) begin
            runFrame(8'($urandom), 1'b0, 0, 1'b1);
            idleCheck(1 + int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
